// File: rtl/conv2_pingpong_ctrl.sv
// rtl/conv2_pingpong_ctrl.sv - ping-pong bank controller for the conv2 BRAM pair
// Producer fills one bank while the consumer drains the other; the block owns every BRAM pin.
module conv2_pingpong_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_last,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              we_arr1,
  output logic              we_arr2,
  output logic [ADDR_W-1:0] addr_arr1_1,
  output logic [ADDR_W-1:0] addr_arr1_2,
  output logic [ADDR_W-1:0] addr_arr2_1,
  output logic [ADDR_W-1:0] addr_arr2_2,
  output logic [DATA_W-1:0] din_arr1_1,
  output logic [DATA_W-1:0] din_arr1_2,
  output logic [DATA_W-1:0] din_arr2_1,
  output logic [DATA_W-1:0] din_arr2_2,
  input  logic [DATA_W-1:0] dout_arr1_1,
  input  logic [DATA_W-1:0] dout_arr2_1,
  output logic [1:0]        bank_full,
  output logic              ovf_err
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } bank_state_t;

  bank_state_t r_state0, r_state1;
  bank_state_t w_state0_nxt, w_state1_nxt;
  logic        r_wr_bank, r_rd_bank;
  logic        r_ovf;
  logic [RD_LAT-1:0] r_rd_vld;
  logic [RD_LAT-1:0] r_rd_tag;

  logic        w_wr_acc, w_rd_acc;
  logic        w_we0, w_we1, w_re0, w_re1;
  bank_state_t w_wr_state, w_rd_state;

  function automatic bank_state_t f_next(input bank_state_t cur, input logic wr_hit,
                                         input logic rd_hit, input logic wl, input logic rl);
    f_next = cur;
    case (cur)
      S_EMPTY, S_FILL: if (wr_hit) f_next = wl ? S_FULL : S_FILL;
      S_FULL, S_DRAIN: if (rd_hit) f_next = rl ? S_EMPTY : S_DRAIN;
      default:         f_next = cur;
    endcase
  endfunction

  assign w_wr_state = r_wr_bank ? r_state1 : r_state0;
  assign w_rd_state = r_rd_bank ? r_state1 : r_state0;
  assign wr_ready   = (w_wr_state == S_EMPTY) || (w_wr_state == S_FILL);
  assign rd_ready   = (w_rd_state == S_FULL)  || (w_rd_state == S_DRAIN);

  // Acceptance is masked during reset so no BRAM pin moves while rst_n is low.
  assign w_wr_acc = rst_n & wr_valid & wr_ready;
  assign w_rd_acc = rst_n & rd_valid & rd_ready;

  assign w_we0 = w_wr_acc & ~r_wr_bank;
  assign w_we1 = w_wr_acc &  r_wr_bank;
  assign w_re0 = w_rd_acc & ~r_rd_bank;
  assign w_re1 = w_rd_acc &  r_rd_bank;

  always_comb begin
    w_state0_nxt = r_state0;
    w_state1_nxt = r_state1;
    w_state0_nxt = f_next(r_state0, w_we0, w_re0, wr_last, rd_last);
    w_state1_nxt = f_next(r_state1, w_we1, w_re1, wr_last, rd_last);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state0  <= S_EMPTY;
      r_state1  <= S_EMPTY;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state0 <= w_state0_nxt;
      r_state1 <= w_state1_nxt;
      if (w_wr_acc && wr_last) r_wr_bank <= ~r_wr_bank;
      if (w_rd_acc && rd_last) r_rd_bank <= ~r_rd_bank;
      r_ovf <= r_ovf | (wr_valid & ~wr_ready) | (rd_valid & ~rd_ready);
    end
  end

  // Valid/tag pipeline matches the BRAM read latency so rd_data muxes the right dout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_vld <= '0;
      r_rd_tag <= '0;
    end else begin
      r_rd_vld[0] <= w_rd_acc;
      r_rd_tag[0] <= r_rd_bank;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
        r_rd_tag[i] <= r_rd_tag[i-1];
      end
    end
  end

  assign rd_data_valid = r_rd_vld[RD_LAT-1];
  assign rd_data       = r_rd_tag[RD_LAT-1] ? dout_arr2_1 : dout_arr1_1;

  assign we_arr1     = w_we0;
  assign we_arr2     = w_we1;
  assign addr_arr1_1 = w_we0 ? wr_addr : (w_re0 ? rd_addr : '0);
  assign addr_arr1_2 = addr_arr1_1;
  assign addr_arr2_1 = w_we1 ? wr_addr : (w_re1 ? rd_addr : '0);
  assign addr_arr2_2 = addr_arr2_1;
  assign din_arr1_1  = w_we0 ? wr_data : '0;
  assign din_arr1_2  = din_arr1_1;
  assign din_arr2_1  = w_we1 ? wr_data : '0;
  assign din_arr2_2  = din_arr2_1;

  assign bank_full[0] = (r_state0 == S_FULL) || (r_state0 == S_DRAIN);
  assign bank_full[1] = (r_state1 == S_FULL) || (r_state1 == S_DRAIN);
  assign ovf_err      = r_ovf;

endmodule

// File: tb/tb_conv2_pingpong_ctrl.sv
// tb/tb_conv2_pingpong_ctrl.sv - self-checking bench for conv2_pingpong_ctrl
// Reference model tracks tiles written/read as counters plus a shadow of each bank.
module tb_conv2_pingpong_ctrl;
  localparam int AW = 12;
  localparam int DW = 64;
  localparam int PW = 2 + 4*AW + 4*DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, wr_valid, wr_ready, wr_last, rd_valid, rd_ready, rd_last;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_data_valid, we_arr1, we_arr2, ovf_err;
  logic [AW-1:0] addr_arr1_1, addr_arr1_2, addr_arr2_1, addr_arr2_2;
  logic [DW-1:0] din_arr1_1, din_arr1_2, din_arr2_1, din_arr2_2;
  logic [DW-1:0] dout_arr1_1, dout_arr2_1;
  logic [1:0]    bank_full;

  conv2_pingpong_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_last(rd_last),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .we_arr1(we_arr1), .we_arr2(we_arr2),
    .addr_arr1_1(addr_arr1_1), .addr_arr1_2(addr_arr1_2),
    .addr_arr2_1(addr_arr2_1), .addr_arr2_2(addr_arr2_2),
    .din_arr1_1(din_arr1_1), .din_arr1_2(din_arr1_2),
    .din_arr2_1(din_arr2_1), .din_arr2_2(din_arr2_2),
    .dout_arr1_1(dout_arr1_1), .dout_arr2_1(dout_arr2_1),
    .bank_full(bank_full), .ovf_err(ovf_err)
  );

  // Single-cycle read-first BRAM models for both banks
  logic          bram_clr;
  logic [DW-1:0] mem1 [4096];
  logic [DW-1:0] mem2 [4096];
  always @(posedge clk) begin
    if (bram_clr) begin
      for (int i = 0; i < 4096; i++) begin
        mem1[i] <= '0;
        mem2[i] <= '0;
      end
      dout_arr1_1 <= '0;
      dout_arr2_1 <= '0;
    end else begin
      if (we_arr1) mem1[addr_arr1_1] <= din_arr1_1;
      if (we_arr2) mem2[addr_arr2_1] <= din_arr2_1;
      dout_arr1_1 <= mem1[addr_arr1_1];
      dout_arr2_1 <= mem2[addr_arr2_1];
    end
  end

  int            n_chk = 0;
  int            n_err = 0;
  int            tw, tr;
  logic          m_ovf, e_dv;
  logic [DW-1:0] e_rd;
  logic [DW-1:0] sh [2][4096];

  logic          obs_wrdy, obs_rrdy, exp_wrdy, exp_rrdy;
  logic [PW-1:0] obs_pins, exp_pins;
  logic [AW-1:0] obs_a11, obs_a21;
  logic          obs_dv, obs_ovf;
  logic [DW-1:0] obs_rd;
  logic [1:0]    obs_bf, exp_bf;

  task automatic step(input logic wv, input logic wl, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic rv, input logic rl, input logic [AW-1:0] ra, input logic rs);
    logic          wb, rb, wacc, racc;
    logic [1:0]    ewe;
    logic [AW-1:0] ea0, ea1;
    logic [DW-1:0] ed0, ed1;
    @(negedge clk);
    rst_n = rs; wr_valid = wv; wr_last = wl; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_last = rl; rd_addr = ra;
    #1;
    wb = tw[0];
    rb = tr[0];
    exp_wrdy = (tw - tr) < 2;
    exp_rrdy = (tw - tr) > 0;
    wacc = rs & wv & exp_wrdy;
    racc = rs & rv & exp_rrdy;
    ewe  = {wacc & wb, wacc & ~wb};
    ea0  = ewe[0] ? wa : ((racc && !rb) ? ra : '0);
    ea1  = ewe[1] ? wa : ((racc &&  rb) ? ra : '0);
    ed0  = ewe[0] ? wd : '0;
    ed1  = ewe[1] ? wd : '0;
    exp_pins = {ewe, ea0, ea0, ea1, ea1, ed0, ed0, ed1, ed1};
    obs_pins = {we_arr2, we_arr1, addr_arr1_1, addr_arr1_2, addr_arr2_1, addr_arr2_2,
                din_arr1_1, din_arr1_2, din_arr2_1, din_arr2_2};
    obs_a11  = addr_arr1_1;
    obs_a21  = addr_arr2_1;
    obs_wrdy = wr_ready;
    obs_rrdy = rd_ready;
    @(posedge clk);
    if (!rs) begin
      tw = 0; tr = 0; m_ovf = 1'b0; e_dv = 1'b0;
    end else begin
      m_ovf = m_ovf | (wv & ~exp_wrdy) | (rv & ~exp_rrdy);
      e_dv  = racc;
      if (racc) e_rd = sh[rb][ra];
      if (wacc) begin
        sh[wb][wa] = wd;
        if (wl) tw++;
      end
      if (racc && rl) tr++;
    end
    exp_bf = 2'b00;
    for (int t = tr; t < tw; t++) exp_bf[t % 2] = 1'b1;
    #1;
    obs_dv  = rd_data_valid;
    obs_rd  = rd_data;
    obs_bf  = bank_full;
    obs_ovf = ovf_err;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 12'd5, 64'hDEAD, 1'b1, 1'b0, 12'd3, 1'b0);
    step(1'b1, 1'b0, 12'd5, 64'hDEAD, 1'b1, 1'b0, 12'd3, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (obs_pins !== '0) begin n_err++; $display("FAIL reset_pins: got %h want 0", obs_pins); end
    n_chk++; if (obs_wrdy !== 1'b1 || obs_rrdy !== 1'b0) begin n_err++; $display("FAIL reset_ready: got wr=%b rd=%b want wr=1 rd=0", obs_wrdy, obs_rrdy); end
    n_chk++; if (obs_dv !== 1'b0 || obs_ovf !== 1'b0) begin n_err++; $display("FAIL reset_flags: got dv=%b ovf=%b want 0 0", obs_dv, obs_ovf); end
    n_chk++; if (obs_bf !== 2'b00) begin n_err++; $display("FAIL reset_bank_full: got %b want 00", obs_bf); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 3, 12'(i), 64'hA0 + 64'(i), 1'b0, 1'b0, '0, 1'b1);
      n_chk++; if (obs_pins[PW-1 -: 2] !== 2'b01) begin n_err++; $display("FAIL basic_we[%0d]: got %b want 01", i, obs_pins[PW-1 -: 2]); end
    end
    n_chk++; if (obs_bf !== 2'b01) begin n_err++; $display("FAIL basic_full: got %b want 01", obs_bf); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, i == 3, 12'(i), 1'b1);
      n_chk++; if (obs_dv !== 1'b1 || obs_rd !== 64'hA0 + 64'(i)) begin n_err++; $display("FAIL basic_rd[%0d]: got dv=%b %h want 1 %h", i, obs_dv, obs_rd, 64'hA0 + 64'(i)); end
    end
    n_chk++; if (obs_bf !== 2'b00) begin n_err++; $display("FAIL basic_empty: got %b want 00", obs_bf); end
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    n_chk++; if (obs_dv !== 1'b0) begin n_err++; $display("FAIL basic_dv_idle: got %b want 0", obs_dv); end
  endtask

  task automatic test_pingpong();
    logic [DW-1:0] d0 [8];
    logic [DW-1:0] d1 [8];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      d0[i] = {$urandom, $urandom};
      step(1'b1, i == 7, 12'(i), d0[i], 1'b0, 1'b0, '0, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      d1[i] = {$urandom, $urandom};
      step(1'b1, i == 7, 12'(i + 16), d1[i], 1'b1, i == 7, 12'(i), 1'b1);
      n_chk++; if (obs_pins[PW-1 -: 2] !== 2'b10 || obs_a11 !== 12'(i)) begin n_err++; $display("FAIL pp_pins[%0d]: got we=%b a11=%0d want 10 %0d", i, obs_pins[PW-1 -: 2], obs_a11, i); end
      n_chk++; if (obs_dv !== 1'b1 || obs_rd !== d0[i]) begin n_err++; $display("FAIL pp_rd0[%0d]: got dv=%b %h want 1 %h", i, obs_dv, obs_rd, d0[i]); end
    end
    n_chk++; if (obs_bf !== 2'b10) begin n_err++; $display("FAIL pp_full: got %b want 10", obs_bf); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, i == 7, 12'(i + 16), 1'b1);
      n_chk++; if (obs_a21 !== 12'(i + 16) || obs_rd !== d1[i]) begin n_err++; $display("FAIL pp_rd1[%0d]: got a21=%0d %h want %0d %h", i, obs_a21, obs_rd, i + 16, d1[i]); end
    end
  endtask

  task automatic test_overflow_wr();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, i[0], 12'(i), 64'(i + 100), 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 12'd9, 64'h77, 1'b0, 1'b0, '0, 1'b1);
    n_chk++; if (obs_wrdy !== 1'b0 || obs_pins[PW-1 -: 2] !== 2'b00) begin n_err++; $display("FAIL ovfw_block: got rdy=%b we=%b want 0 00", obs_wrdy, obs_pins[PW-1 -: 2]); end
    n_chk++; if (obs_ovf !== 1'b1) begin n_err++; $display("FAIL ovfw_set: got %b want 1", obs_ovf); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    n_chk++; if (obs_ovf !== 1'b1) begin n_err++; $display("FAIL ovfw_sticky: got %b want 1", obs_ovf); end
    do_reset();
    n_chk++; if (obs_ovf !== 1'b0) begin n_err++; $display("FAIL ovfw_clear: got %b want 0", obs_ovf); end
  endtask

  task automatic test_overflow_rd();
    do_reset();
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'd2, 1'b1);
    n_chk++; if (obs_rrdy !== 1'b0 || obs_dv !== 1'b0) begin n_err++; $display("FAIL ovfr_block: got rdy=%b dv=%b want 0 0", obs_rrdy, obs_dv); end
    n_chk++; if (obs_ovf !== 1'b1) begin n_err++; $display("FAIL ovfr_set: got %b want 1", obs_ovf); end
  endtask

  task automatic test_single_word();
    do_reset();
    step(1'b1, 1'b1, 12'd7, 64'h55, 1'b0, 1'b0, '0, 1'b1);
    n_chk++; if (obs_bf !== 2'b01) begin n_err++; $display("FAIL single_full: got %b want 01", obs_bf); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'd7, 1'b1);
    n_chk++; if (obs_dv !== 1'b1 || obs_rd !== 64'h55 || obs_bf !== 2'b00) begin n_err++; $display("FAIL single_rd: got dv=%b %h bf=%b want 1 55 00", obs_dv, obs_rd, obs_bf); end
    step(1'b1, 1'b1, 12'd3, 64'h66, 1'b0, 1'b0, '0, 1'b1);
    n_chk++; if (obs_pins[PW-1 -: 2] !== 2'b10) begin n_err++; $display("FAIL single_wrbank: got we=%b want 10", obs_pins[PW-1 -: 2]); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'd3, 1'b1);
    n_chk++; if (obs_a21 !== 12'd3 || obs_rd !== 64'h66) begin n_err++; $display("FAIL single_rdbank: got a21=%0d %h want 3 66", obs_a21, obs_rd); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, i == 3, 12'(i), 64'(i + 200), 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 12'd0, 64'h123, 1'b1, 1'b0, 12'd0, 1'b1);
    step(1'b1, 1'b0, 12'd1, 64'h124, 1'b1, 1'b0, 12'd1, 1'b0);
    n_chk++; if (obs_dv !== 1'b0 || obs_pins[PW-1 -: 2] !== 2'b00) begin n_err++; $display("FAIL midrst_dv_we: got dv=%b we=%b want 0 00", obs_dv, obs_pins[PW-1 -: 2]); end
    step(1'b1, 1'b0, 12'd9, 64'h99, 1'b1, 1'b0, 12'd0, 1'b1);
    n_chk++; if (obs_wrdy !== 1'b1 || obs_rrdy !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got wr=%b rd=%b want 1 0", obs_wrdy, obs_rrdy); end
    n_chk++; if (obs_pins[PW-1 -: 2] !== 2'b01 || obs_dv !== 1'b0) begin n_err++; $display("FAIL midrst_bank0: got we=%b dv=%b want 01 0", obs_pins[PW-1 -: 2], obs_dv); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 4) == 0, 12'($urandom_range(0, 15)), {$urandom, $urandom},
           $urandom_range(0, 9) < 5, $urandom_range(0, 4) == 0, 12'($urandom_range(0, 15)),
           $urandom_range(0, 63) != 0);
      n_chk++; if (obs_pins !== exp_pins) begin n_err++; $display("FAIL rnd_pins@%0d: got %h want %h", n, obs_pins, exp_pins); end
      n_chk++; if (obs_wrdy !== exp_wrdy || obs_rrdy !== exp_rrdy) begin n_err++; $display("FAIL rnd_ready@%0d: got %b%b want %b%b", n, obs_wrdy, obs_rrdy, exp_wrdy, exp_rrdy); end
      n_chk++; if (obs_dv !== e_dv) begin n_err++; $display("FAIL rnd_dv@%0d: got %b want %b", n, obs_dv, e_dv); end
      if (e_dv) begin
        n_chk++; if (obs_rd !== e_rd) begin n_err++; $display("FAIL rnd_rd@%0d: got %h want %h", n, obs_rd, e_rd); end
      end
      n_chk++; if (obs_bf !== exp_bf || obs_ovf !== m_ovf) begin n_err++; $display("FAIL rnd_flags@%0d: got bf=%b ovf=%b want %b %b", n, obs_bf, obs_ovf, exp_bf, m_ovf); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_last = 1'b0; rd_addr = '0;
    bram_clr = 1'b1;
    tw = 0; tr = 0; m_ovf = 1'b0; e_dv = 1'b0; e_rd = '0;
    for (int i = 0; i < 4096; i++) begin
      sh[0][i] = '0;
      sh[1][i] = '0;
    end
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    bram_clr = 1'b0;
    test_reset();
    test_basic();
    test_pingpong();
    test_overflow_wr();
    test_overflow_rd();
    test_single_word();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
